// File: rtl/mm_pkg.sv
// Shared types and default sizing for the guess scorer.
package mm_pkg;
  localparam int DEF_N_PEGS    = 4;
  localparam int DEF_COLOR_W   = 2;
  localparam int DEF_MAX_TRIES = 10;

  typedef enum logic [1:0] {S_IDLE, S_EXACT, S_COLOR, S_DONE} state_t;

  typedef logic [DEF_COLOR_W-1:0] peg_t;
endpackage

// File: rtl/color_histogram.sv
// Secret/guess colour histograms of the mismatched pegs, plus the
// min-accumulate that turns them into the white-peg count.
module color_histogram
  import mm_pkg::*;
#(
  parameter int N_PEGS  = DEF_N_PEGS,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        i_clr,
  input  logic                        i_peg_en,
  input  logic [COLOR_W-1:0]          i_s_col,
  input  logic [COLOR_W-1:0]          i_g_col,
  input  logic                        i_col_en,
  input  logic [COLOR_W-1:0]          i_col,
  output logic [$clog2(N_PEGS+1)-1:0] o_white
);
  localparam int NCOL  = 1 << COLOR_W;
  localparam int CNT_W = $clog2(N_PEGS+1);

  logic [NCOL-1:0][CNT_W-1:0] r_hist_s, r_hist_g;
  logic [CNT_W-1:0]           r_white, w_hs, w_hg, w_min;

  assign w_hs  = r_hist_s[i_col];
  assign w_hg  = r_hist_g[i_col];
  assign w_min = (w_hs < w_hg) ? w_hs : w_hg;

  // i_peg_en is only raised on a mismatch, so the two bins written never alias
  always_ff @(posedge CLK) begin
    if (reset || i_clr) begin
      r_hist_s <= '0;
      r_hist_g <= '0;
      r_white  <= '0;
    end else begin
      if (i_peg_en) begin
        r_hist_s[i_s_col] <= r_hist_s[i_s_col] + 1'b1;
        r_hist_g[i_g_col] <= r_hist_g[i_g_col] + 1'b1;
      end
      if (i_col_en) r_white <= r_white + w_min;
    end
  end

  assign o_white = r_white;
endmodule

// File: rtl/guess_scorer.sv
// Mastermind-style guess scorer: one peg per cycle, then one colour per cycle.
// Define MM_ATTEMPT_LIMIT_EN to end the game (lose) after MAX_TRIES misses.
module guess_scorer
  import mm_pkg::*;
#(
  parameter int N_PEGS    = DEF_N_PEGS,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           start,
  input  logic [N_PEGS*COLOR_W-1:0]      secret,
  input  logic [N_PEGS*COLOR_W-1:0]      guess,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N_PEGS+1)-1:0]    black,
  output logic [$clog2(N_PEGS+1)-1:0]    white,
  output logic [$clog2(MAX_TRIES+1)-1:0] attempts,
  output logic                           win,
  output logic                           lose
);
  localparam int NCOL  = 1 << COLOR_W;
  localparam int CNT_W = $clog2(N_PEGS+1);
  localparam int ATT_W = $clog2(MAX_TRIES+1);
  localparam int IDX_W = $clog2(N_PEGS+NCOL+1);
  localparam logic [IDX_W-1:0] LAST_PEG  = IDX_W'(N_PEGS-1);
  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(NCOL-1);
  localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] ALL_BLACK = CNT_W'(N_PEGS);

  state_t                    r_state, w_state_nx;
  logic [N_PEGS*COLOR_W-1:0] r_secret, r_guess;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_black;
  logic [ATT_W-1:0]          r_attempts, w_att_nx;
  logic                      r_done, r_win;
  logic                      w_accept, w_match, w_lose, w_peg_en, w_col_en;
  logic [COLOR_W-1:0]        w_s_peg, w_g_peg;

  assign w_s_peg  = COLOR_W'(r_secret >> (int'(r_idx) * COLOR_W));
  assign w_g_peg  = COLOR_W'(r_guess  >> (int'(r_idx) * COLOR_W));
  assign w_match  = (w_s_peg == w_g_peg);
  assign w_accept = (r_state == S_IDLE) && start && !r_win && !w_lose;
  assign w_peg_en = (r_state == S_EXACT) && !w_match;
  assign w_col_en = (r_state == S_COLOR);
  assign w_att_nx = (r_attempts == ATT_MAX) ? r_attempts : r_attempts + 1'b1;

  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)           w_state_nx = S_EXACT;
      S_EXACT: if (r_idx == LAST_PEG)  w_state_nx = S_COLOR;
      S_COLOR: if (r_idx == LAST_COL)  w_state_nx = S_DONE;
      S_DONE:                          w_state_nx = S_IDLE;
      default:                         w_state_nx = S_IDLE;
    endcase
  end

  // r_idx walks pegs in EXACT, restarts at 0, then walks colours in COLOR
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_secret   <= '0;
      r_guess    <= '0;
      r_idx      <= '0;
      r_black    <= '0;
      r_attempts <= '0;
      r_done     <= 1'b0;
      r_win      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_secret <= secret;
          r_guess  <= guess;
          r_black  <= '0;
          r_idx    <= '0;
        end
        S_EXACT: begin
          if (w_match) r_black <= r_black + 1'b1;
          r_idx <= (r_idx == LAST_PEG) ? '0 : r_idx + 1'b1;
        end
        S_COLOR: r_idx <= r_idx + 1'b1;
        S_DONE: begin
          r_done     <= 1'b1;
          r_attempts <= w_att_nx;
          if (r_black == ALL_BLACK) r_win <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MM_ATTEMPT_LIMIT_EN
  logic r_lose;
  always_ff @(posedge CLK) begin
    if (reset)
      r_lose <= 1'b0;
    else if (r_state == S_DONE && r_black != ALL_BLACK && w_att_nx == ATT_MAX)
      r_lose <= 1'b1;
  end
  assign w_lose = r_lose;
`else
  assign w_lose = 1'b0;
`endif

  color_histogram #(.N_PEGS(N_PEGS), .COLOR_W(COLOR_W)) u_hist (
    .CLK      (CLK),
    .reset    (reset),
    .i_clr    (w_accept),
    .i_peg_en (w_peg_en),
    .i_s_col  (w_s_peg),
    .i_g_col  (w_g_peg),
    .i_col_en (w_col_en),
    .i_col    (r_idx[COLOR_W-1:0]),
    .o_white  (white)
  );

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign black    = r_black;
  assign attempts = r_attempts;
  assign win      = r_win;
  assign lose     = w_lose;
endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 SHALL provide parameter N_PEGS, default 4, number of pegs per code.
REQ-002 SHALL provide parameter COLOR_W, default 2, bits per peg colour; the number of colours is 2^COLOR_W.
REQ-003 SHALL provide parameter MAX_TRIES, default 10, number of guesses allowed per game.
REQ-004 SHALL provide CLK, input, 1, the single clock; all state updates occur on the rising edge.
REQ-005 SHALL provide reset, input, 1, synchronous active-high reset sampled on the rising edge of CLK.
REQ-006 SHALL provide start, input, 1, a one-cycle request to score the current guess.
REQ-007 SHALL provide secret, input, N_PEGS*COLOR_W, the secret code from the code registers; peg i occupies [i*COLOR_W +: COLOR_W].
REQ-008 SHALL provide guess, input, N_PEGS*COLOR_W, the player guess from the guess registers, packed the same way as secret.
REQ-009 SHALL provide busy, output, 1, asserted while scoring is in progress.
REQ-010 SHALL provide done, output, 1, a one-cycle pulse when the score is valid.
REQ-011 SHALL provide black, output, clog2(N_PEGS+1), the count of pegs with the right colour in the right position.
REQ-012 SHALL provide white, output, clog2(N_PEGS+1), the count of pegs with the right colour in the wrong position.
REQ-013 SHALL provide attempts, output, clog2(MAX_TRIES+1), the number of guesses scored so far.
REQ-014 SHALL provide win, output, 1, sticky; set when a guess scores black == N_PEGS.
REQ-015 SHALL provide lose, output, 1, sticky; set when attempts reaches MAX_TRIES without a win.

Function
REQ-016 SHALL implement the FSM states IDLE, EXACT, COLOR and DONE.
REQ-017 In IDLE, start=1 with win=0 and lose=0 SHALL latch secret and guess, clear the black, white and histogram registers, and enter EXACT.
REQ-018 In EXACT, the FSM SHALL process one peg per cycle, index 0..N_PEGS-1: on a match black increments; on a mismatch the secret-colour and guess-colour histogram bins each increment. After the last peg it SHALL enter COLOR.
REQ-019 In COLOR, the FSM SHALL process one colour per cycle, 0..2^COLOR_W-1, adding white += min(hist_s[c], hist_g[c]). After the last colour it SHALL enter DONE.
REQ-020 In DONE, for one cycle, done=1 and attempts increments (saturating at MAX_TRIES). win sets if black==N_PEGS; otherwise lose sets if the new attempts value equals MAX_TRIES. The FSM then returns to IDLE.
REQ-021 Latency from the start-sampling edge to done=1 SHALL be N_PEGS+2^COLOR_W+1 cycles (9 with defaults).
REQ-022 busy SHALL be 1 in EXACT, COLOR and DONE, and 0 in IDLE.
REQ-023 black and white SHALL hold their DONE values until the next accepted start.
REQ-024 start SHALL be ignored while busy=1, or while win=1 or lose=1.
REQ-025 Changes to secret and guess after acceptance SHALL NOT affect the score in progress.
REQ-026 Histogram bins SHALL be wide enough (clog2(N_PEGS+1)) that they never overflow.

Reset
REQ-027 reset=1 SHALL force IDLE and set busy=0, done=0, black=0, white=0, attempts=0, win=0, lose=0 and all histograms to 0 on the next edge.
REQ-028 reset SHALL take priority over start in the same cycle and SHALL abort any scoring in progress.

Configuration
REQ-029 With macro MM_ATTEMPT_LIMIT_EN defined, attempts SHALL be limited and lose SHALL behave per REQ-020.
REQ-030 Without MM_ATTEMPT_LIMIT_EN, lose SHALL be tied to 0, attempts SHALL still count (saturating at MAX_TRIES), and games SHALL be unlimited until a win.

Structure
REQ-031 Package mm_pkg SHALL hold the state enum, default N_PEGS/COLOR_W/MAX_TRIES constants and the peg-colour typedef.
REQ-032 The histogram pair and the min-accumulate logic SHALL be placed in one sub-module, color_histogram; all control stays in guess_scorer.

Verification
REQ-033 secret={3,2,1,0}, guess={3,2,1,0}, start -> done 9 cycles later, black=4, white=0, win=1, attempts=1.
REQ-034 secret={3,2,1,0}, guess={0,1,2,3} -> black=0, white=4, win=0.
REQ-035 secret={1,1,2,2}, guess={1,2,1,0} (peg3..peg0) -> black=1, white=2.
REQ-036 With MM_ATTEMPT_LIMIT_EN, 10 non-winning guesses -> lose=1 after the 10th done; an 11th start produces no busy and no done.
REQ-037 reset=1 on the 4th cycle after start -> next cycle busy=0, black=0, white=0; done never pulses.
REQ-038 A start pulse while busy=1 -> ignored; exactly one done is produced and attempts increments by 1.
